// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one time-shared full-adder cell.
// Define SADD_SUB_EN to enable two's-complement subtract via the sub input.
module serial_add_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;

   logic             h1;
   logic             c1;
   logic             s;
   logic             c2;
   logic             carry_d;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] sb_ld;
   logic             cin0;
   logic             last;

   // Two chained half adders plus the carry flop form the full-adder cell.
   always_comb begin
      h1      = sa_q[0] ^ sb_q[0];
      c1      = sa_q[0] & sb_q[0];
      s       = h1 ^ carry_q;
      c2      = h1 & carry_q;
      carry_d = c1 | c2;
      res_d   = {s, res_q[WIDTH-1:1]};
   end

   assign last = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SADD_SUB_EN
   assign sb_ld = sub ? ~b : b;
   assign cin0  = sub;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign sb_ld      = b;
   assign cin0       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (ena) begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  sa_q    <= a;
                  sb_q    <= sb_ld;
                  carry_q <= cin0;
                  cnt_q   <= '0;
                  res_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               sa_q    <= sa_q >> 1;
               sb_q    <= sb_q >> 1;
               carry_q <= carry_d;
               res_q   <= res_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last) begin
                  state_q <= DONE;
                  sum_q   <= res_d;
                  cout_q  <= carry_d;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=4).
// Behavioural model plus directed literal cases and random traffic.
module tb_serial_add_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   serial_add_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .start (start),
      .a     (a),
      .b     (b),
      .sub   (sub),
      .sum   (sum),
      .cout  (cout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W:0] ref_result(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic s);
      logic inv;
      inv = 1'b0;
`ifdef SADD_SUB_EN
      inv = s;
`else
      if (s) inv = 1'b0;
`endif
      return {1'b0, x} + {1'b0, inv ? ~y : y} + {{W{1'b0}}, inv};
   endfunction

   // Model: rem counts remaining busy cycles; the result lands one cycle before idle.
   int           rem = 0;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0;
   logic [W-1:0] p_sum = '0;
   logic         p_cout = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         rem    <= 0;
         m_sum  <= '0;
         m_cout <= 1'b0;
      end else if (ena) begin
         if (rem == 0) begin
            if (start) begin
               rem <= W + 1;
               {p_cout, p_sum} <= ref_result(a, b, sub);
            end
         end else begin
            rem <= rem - 1;
            if (rem == 2) begin
               m_sum  <= p_sum;
               m_cout <= p_cout;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_sum", int'(sum), int'(m_sum));
         chk("model_cout", int'(cout), int'(m_cout));
         chk("model_busy", int'(busy), int'(rem > 0));
         chk("model_done", int'(done), int'(rem == 1));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s);
      a     = x;
      b     = y;
      sub   = s;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n++;
         if (done) break;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic op(input string nm, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic s,
                     input int es, input int ec);
      int n;
      launch(x, y, s);
      wait_done(n);
      chk({nm, "_lat"}, n, W);
      chk({nm, "_sum"}, int'(sum), es);
      chk({nm, "_cout"}, int'(cout), ec);
      chk({nm, "_busy"}, int'(busy), 1);
      tick();
      chk({nm, "_idle"}, int'(busy), 0);
   endtask

   initial begin
      int n;
      int dn;
      rst_n = 1'b0;
      ena   = 1'b0;
      tick();
      tick();
      chk_en = 1'b1;
      chk("rst_sum", int'(sum), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      ena   = 1'b1;
      tick();

      op("add", 4'd3, 4'd5, 1'b0, 8, 0);
      op("ovf1", 4'd15, 4'd1, 1'b0, 0, 1);
      op("ovf2", 4'd15, 4'd15, 1'b0, 14, 1);
`ifdef SADD_SUB_EN
      op("sub1", 4'd5, 4'd3, 1'b1, 2, 1);
      op("sub2", 4'd3, 4'd5, 1'b1, 14, 0);
`else
      op("sub1", 4'd5, 4'd3, 1'b1, 8, 0);
      op("sub2", 4'd3, 4'd5, 1'b1, 8, 0);
`endif

      // Start during RUN must be ignored.
      launch(4'd3, 4'd5, 1'b0);
      tick();
      tick();
      a     = 4'd1;
      b     = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done) dn++;
      end
      chk("bsy_dones", dn, 1);
      chk("bsy_sum", int'(sum), 8);

      // Reset in the third RUN cycle.
      launch(4'd7, 4'd6, 1'b0);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_done", int'(done), 0);
      chk("mrst_sum", int'(sum), 0);
      chk("mrst_cout", int'(cout), 0);
      op("post_rst", 4'd2, 4'd9, 1'b0, 11, 0);

      // Three-cycle stall right after the first bit step.
      launch(4'd6, 4'd7, 1'b0);
      tick();
      ena = 1'b0;
      tick();
      tick();
      tick();
      ena = 1'b1;
      wait_done(n);
      chk("stall_lat", 1 + 3 + n, W + 3);
      chk("stall_sum", int'(sum), 13);
      tick();

      // Held start restarts every W+2 cycles.
      a     = 4'd9;
      b     = 4'd4;
      start = 1'b1;
      dn    = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dn++;
      end
      start = 1'b0;
      chk("held_dones", dn, 2);
      chk("held_sum", int'(sum), 13);
      for (int i = 0; i < 8; i++) tick();

      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 79) != 0);
         ena   = ($urandom_range(0, 5) != 0);
         start = ($urandom_range(0, 2) == 0);
         a     = W'($urandom);
         b     = W'($urandom);
         sub   = 1'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
